// File: rtl/aq_dtu_cdc_hs_rcv_pkg.sv
// ---------------------------------------------------------------------------
// aq_dtu_cdc_hs_rcv_pkg
//   Shared DTU definitions for the CDC handshake receiver:
//   - receiver FSM state encoding (IDLE / VALID / ACK)
//   - legal bounds for the request synchronizer depth
//   - a small helper that checks a synchronizer depth against those bounds
// ---------------------------------------------------------------------------
package aq_dtu_cdc_hs_rcv_pkg;

  localparam logic [1:0] STATE_IDLE  = 2'b00;
  localparam logic [1:0] STATE_VALID = 2'b01;
  localparam logic [1:0] STATE_ACK   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = STATE_IDLE,
    ST_VALID = STATE_VALID,
    ST_ACK   = STATE_ACK
  } rcv_state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  function automatic bit sync_stages_ok(input int n);
    return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/aq_dtu_cdc_sync.sv
// ---------------------------------------------------------------------------
// aq_dtu_cdc_sync
//   N-stage single-bit level synchronizer. Shared by the DTU receive and
//   transmit CDC blocks.
//
// Parameters
//   STAGES  number of flops in the chain
//
// Ports
//   clk     destination clock
//   rst     asynchronous active-high reset, clears every stage to 0
//   d       asynchronous input level
//   q       synchronized level (output of the last stage)
// ---------------------------------------------------------------------------
module aq_dtu_cdc_sync #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/aq_dtu_cdc_hs_rcv.sv
// ---------------------------------------------------------------------------
// aq_dtu_cdc_hs_rcv
//   Receiving end of a 4-phase level req/ack handshake. The request level is
//   synchronized into dst_clk, the payload is captured once on the IDLE->VALID
//   edge, handed to the local consumer with valid/ready, and an acknowledge
//   level is returned from a flop.
//
// Build option
//   AQ_DTU_CDC_RCV_PAR_EN  adds src_par / dst_par_err and an even-parity check
//                          of {src_data, src_par} on the capture edge.
//
// Parameters
//   DATA_W       payload width
//   SYNC_STAGES  request synchronizer depth (2..4)
//
// Ports
//   dst_clk      clock
//   dst_rst      asynchronous active-high reset
//   src_req      request level from the foreign domain (asynchronous)
//   src_data     payload, stable while src_req is high and src_ack is low
//   src_par      even parity over src_data (parity build only)
//   src_ack      acknowledge level back to the sender (flop output)
//   dst_vld      captured word available
//   dst_data     captured word
//   dst_rdy      consumer accepts the word
//   dst_par_err  one-cycle pulse on the first VALID cycle of a bad word
//                (parity build only)
//   dbg_state    current FSM state, for observation only
//
// Consumer handshake: a word transfers on every rising edge where dst_vld and
// dst_rdy are both high; dst_data is stable while dst_vld is high, and dst_vld
// does not depend combinationally on dst_rdy.
// ---------------------------------------------------------------------------
module aq_dtu_cdc_hs_rcv
  import aq_dtu_cdc_hs_rcv_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 3
) (
  input  logic              dst_clk,
  input  logic              dst_rst,
  input  logic              src_req,
  input  logic [DATA_W-1:0] src_data,
`ifdef AQ_DTU_CDC_RCV_PAR_EN
  input  logic              src_par,
  output logic              dst_par_err,
`endif
  output logic              src_ack,
  output logic              dst_vld,
  output logic [DATA_W-1:0] dst_data,
  input  logic              dst_rdy,
  output logic [1:0]        dbg_state
);

  if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync_stages
    $error("aq_dtu_cdc_hs_rcv: SYNC_STAGES out of range");
  end

  logic              req_s;
  rcv_state_e        state_q;
  logic [DATA_W-1:0] hold_q;
  logic              ack_q;
  logic              vld_q;

  aq_dtu_cdc_sync #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk (dst_clk),
    .rst (dst_rst),
    .d   (src_req),
    .q   (req_s)
  );

`ifdef AQ_DTU_CDC_RCV_PAR_EN
  logic par_err_q;
`endif

  // Leaving ACK waits for req_s low, so a long-held request is never
  // captured twice. An early drop of src_req during VALID simply makes
  // the ACK phase last one cycle.
  always_ff @(posedge dst_clk or posedge dst_rst) begin
    if (dst_rst) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      ack_q     <= 1'b0;
      vld_q     <= 1'b0;
`ifdef AQ_DTU_CDC_RCV_PAR_EN
      par_err_q <= 1'b0;
`endif
    end else begin
`ifdef AQ_DTU_CDC_RCV_PAR_EN
      par_err_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (req_s) begin
            hold_q  <= src_data;
            vld_q   <= 1'b1;
            state_q <= ST_VALID;
`ifdef AQ_DTU_CDC_RCV_PAR_EN
            // Odd total parity flags the word for exactly the first VALID cycle.
            par_err_q <= ^{src_data, src_par};
`endif
          end
        end
        ST_VALID: begin
          if (dst_rdy) begin
            vld_q   <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!req_s) begin
            ack_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          vld_q   <= 1'b0;
          ack_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign src_ack   = ack_q;
  assign dst_vld   = vld_q;
  assign dst_data  = hold_q;
  assign dbg_state = state_q;
`ifdef AQ_DTU_CDC_RCV_PAR_EN
  assign dst_par_err = par_err_q;
`endif

endmodule
